// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS front-end widths, constants and fetch entry type
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - parameterised-depth synchronous FIFO with flush and registered head
module fetch_queue #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  output T                 rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rdata = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC, imem request/response, instruction queue
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  outstanding, iq_count;
  logic              tag_full, tag_empty, iq_full, iq_empty;
  logic [ADDR_W-1:0] tag_pc;
  fetch_entry_t      iq_wdata, iq_head;
  logic              pop, grant, rvalid_ok, iq_push;

  assign pop       = if_valid && if_ready;
  assign grant     = imem_req && imem_gnt;
  assign rvalid_ok = imem_rvalid && !tag_empty;
  assign iq_push   = rvalid_ok && (discard_q == '0) && !redirect_valid;
  assign iq_wdata  = '{pc: tag_pc, instr: imem_rdata};

  assign imem_addr      = pc_q;
  assign if_valid       = !iq_empty;
  assign if_pc          = iq_head.pc;
  assign if_instruction = iq_head.instr;

  // Credit rule: in-flight plus buffered never exceeds the queue depth.
  assign imem_req = rst_n && !redirect_valid &&
                    (int'(outstanding) + int'(iq_count) - int'(pop) < DEPTH);

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~ADDR_W'(3);
      discard_d = outstanding - CNT_W'(rvalid_ok);
    end else begin
      if (grant) pc_d = pc_q + ADDR_W'(PC_STEP);
      if (rvalid_ok && discard_q != '0) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // Tags survive a redirect so squashed responses still pair up in order.
  fetch_queue #(.DEPTH(DEPTH), .T(logic [ADDR_W-1:0])) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (grant),
    .wdata (pc_q),
    .pop   (rvalid_ok),
    .rdata (tag_pc),
    .count (outstanding),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_queue #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (iq_push),
    .wdata (iq_wdata),
    .pop   (pop),
    .rdata (iq_head),
    .count (iq_count),
    .full  (iq_full),
    .empty (iq_empty)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> !tag_empty);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant && tag_full && !rvalid_ok));
  a_no_iq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(iq_push && iq_full && !pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instruction, if_pc;

  logic        w_imem_req, w_gnt, w_rvalid, w_if_valid;
  logic [31:0] w_imem_addr, w_rdata, w_if_instruction, w_if_pc;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  int          vectors, miscompares;
  int          cyc, lat, pops, first_valid;
  logic [31:0] exp_pc, w_exp_pc;
  logic [31:0] sb[$];
  logic [31:0] w_sb[$];
  logic [31:0] w_log[$];
  mreq_t       mq[$];
  logic        w_pend;
  logic [31:0] w_pend_addr;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instruction(if_instruction), .if_pc(if_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .if_valid(w_if_valid), .if_ready(if_ready),
    .if_instruction(w_if_instruction), .if_pc(w_if_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    w_rvalid = w_pend;
    w_rdata  = mem_word(w_pend_addr);
    #1;
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (sb.size() == 0) check("stale_if_valid", 32'(if_valid), 0);
    else if (if_valid) begin
      check("if_pc", if_pc, sb[0]);
      check("if_instruction", if_instruction, mem_word(sb[0]));
      if (if_ready) begin
        void'(sb.pop_front());
        pops++;
      end
    end
    if (redirect_valid) begin
      check("req_in_redirect", 32'(imem_req), 0);
      sb.delete();
      exp_pc = redirect_pc & ~32'h3;
    end else if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, exp_pc);
      sb.push_back(exp_pc);
      mq.push_back('{exp_pc, cyc + lat});
      exp_pc += 4;
    end
    if (w_sb.size() == 0) check("w_stale_if_valid", 32'(w_if_valid), 0);
    else if (w_if_valid) begin
      check("w_if_pc", w_if_pc, w_sb[0]);
      check("w_if_instruction", w_if_instruction, mem_word(w_sb[0]));
      if (if_ready) void'(w_sb.pop_front());
    end
    w_pend = w_imem_req && w_gnt;
    if (w_pend) begin
      check("w_imem_addr", w_imem_addr, w_exp_pc);
      w_sb.push_back(w_exp_pc);
      w_log.push_back(w_exp_pc);
      w_pend_addr = w_exp_pc;
      w_exp_pc += 4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    w_rvalid       = 1'b0;
    redirect_valid = 1'b0;
    mq.delete();
    sb.delete();
    w_sb.delete();
    w_log.delete();
    w_pend = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instruction", if_instruction, 0);
    rst_n       = 1'b1;
    cyc         = 0;
    lat         = l;
    pops        = 0;
    first_valid = -1;
    exp_pc      = 32'h0;
    w_exp_pc    = 32'hFFFF_FFF8;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; lat = 1; pops = 0; first_valid = -1;
    rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = '0; w_redirect_valid = 1'b0; w_redirect_pc = '0;
    w_pend = 1'b0; w_pend_addr = '0; exp_pc = '0; w_exp_pc = '0;

    // Streaming with a 1-cycle memory and decode always ready
    do_reset(1);
    #1;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", imem_addr, 32'h0);
    repeat (10) tick();
    check("first_valid_cycle", first_valid, 2);
    check("stream_pops", pops, 8);
    check("w_grants", w_log.size(), 10);
    check("w_wrap_fffc", w_log[1], 32'hFFFF_FFFC);
    check("w_wrap_zero", w_log[2], 32'h0000_0000);

    // Backpressure: queue fills, requests stop, head holds
    if_ready = 1'b0;
    do_reset(1);
    repeat (5) tick();
    check("stall_if_valid", 32'(if_valid), 1);
    check("stall_if_pc", if_pc, 32'h0);
    check("stall_req", 32'(imem_req), 0);
    if_ready = 1'b1;
    pops = 0;
    repeat (3) tick();
    check("release_pops", pops, 3);

    // Redirect with two responses outstanding on a 3-cycle memory
    do_reset(3);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_req", 32'(imem_req), 1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    first_valid = -1;
    repeat (8) tick();
    check("redir_first_valid", first_valid, 8);

    // Redirect coinciding with rvalid and a decode pop
    do_reset(1);
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("flush_if_valid", 32'(if_valid), 0);
    check("flush_req", 32'(imem_req), 1);
    check("flush_addr", imem_addr, 32'h0000_2000);
    first_valid = -1;
    repeat (4) tick();
    check("flush_first_valid", first_valid, 8);

    // Asynchronous reset while the queue is full
    if_ready = 1'b0;
    do_reset(1);
    repeat (5) tick();
    check("full_if_valid", 32'(if_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_if_valid", 32'(if_valid), 0);
    check("async_req", 32'(imem_req), 0);
    check("async_w_if_valid", 32'(w_if_valid), 0);
    if_ready = 1'b1;
    do_reset(1);
    #1;
    check("restart_addr", imem_addr, 32'h0);
    check("restart_w_addr", w_imem_addr, 32'hFFFF_FFF8);
    repeat (4) tick();
    check("restart_pops", pops, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
